// File: rtl/inventory_tracker_if.sv
// Execution / config / query bus of the inventory tracker.
// master drives requests and samples results; slave is the tracker.
interface inventory_tracker_if #(
  parameter int NUM_STOCKS   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int FP_WORD_SIZE = 64
);
  localparam int IDW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;

  logic                        i_cfg_we;
  logic [IDW-1:0]              i_cfg_stock_id;
  logic [DATA_WIDTH-1:0]       i_cfg_max_position;
  logic [FP_WORD_SIZE-1:0]     i_cfg_max_inv_reciprocal;
  logic                        i_execute_order;
  logic [IDW-1:0]              i_execute_stock_id;
  logic                        i_execute_order_side;
  logic [DATA_WIDTH-1:0]       i_execute_order_quantity;
  logic                        i_query_valid;
  logic [IDW-1:0]              i_query_stock_id;
  logic                        o_norm_valid;
  logic [IDW-1:0]              o_norm_stock_id;
  logic signed [FP_WORD_SIZE-1:0] o_norm_inventory;
  logic signed [DATA_WIDTH:0]  o_inventory;
  logic                        o_limit_hit;
  logic [IDW-1:0]              o_limit_stock_id;

  modport master (
    output i_cfg_we, i_cfg_stock_id, i_cfg_max_position, i_cfg_max_inv_reciprocal,
    output i_execute_order, i_execute_stock_id, i_execute_order_side, i_execute_order_quantity,
    output i_query_valid, i_query_stock_id,
    input  o_norm_valid, o_norm_stock_id, o_norm_inventory, o_inventory,
    input  o_limit_hit, o_limit_stock_id
  );

  modport slave (
    input  i_cfg_we, i_cfg_stock_id, i_cfg_max_position, i_cfg_max_inv_reciprocal,
    input  i_execute_order, i_execute_stock_id, i_execute_order_side, i_execute_order_quantity,
    input  i_query_valid, i_query_stock_id,
    output o_norm_valid, o_norm_stock_id, o_norm_inventory, o_inventory,
    output o_limit_hit, o_limit_stock_id
  );
endinterface

// File: rtl/inventory_tracker.sv
// Per-stock clamped signed position tracker with a 2-cycle normalised-inventory query pipeline.
// Latency: query -> result 2 cycles, execute -> limit flag 1 cycle; no backpressure, one query per cycle.
module inventory_tracker #(
  parameter int NUM_STOCKS   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int FP_WORD_SIZE = 64,
  parameter int FP_FRAC_BITS = 32
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  inventory_tracker_if.slave bus
);
  localparam int IDW      = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam int DW       = DATA_WIDTH;
  localparam int FW       = FP_WORD_SIZE;
  localparam int PW       = DW + FW + 2;
  localparam int INT_BITS = FW - FP_FRAC_BITS;
  localparam logic [IDW:0] NUM_ID = NUM_STOCKS[IDW:0];

  logic signed [DW:0]   pos_q [NUM_STOCKS];
  logic [DW-1:0]        max_q [NUM_STOCKS];
  logic [FW-1:0]        rec_q [NUM_STOCKS];

  logic                 s1_vld_q;
  logic [IDW-1:0]       s1_id_q;
  logic signed [DW:0]   s1_pos_q;
  logic [FW-1:0]        s1_rec_q;

  logic                 norm_vld_q;
  logic [IDW-1:0]       norm_id_q;
  logic signed [FW-1:0] norm_q;
  logic signed [DW:0]   inv_q;
  logic                 lim_hit_q;
  logic [IDW-1:0]       lim_id_q;

  // ---------------- execute path ----------------
  logic                 exe_in, exe_ok, cfg_ok, q_in;
  logic [IDW-1:0]       exe_idx, q_idx;
  logic signed [DW+1:0] pos_ext_d, qty_ext_d, lim_ext_d, sum_d, clamp_d;
  logic signed [DW:0]   pos_next_d;
  logic                 hit_d;

  always_comb begin
    exe_in    = ({1'b0, bus.i_execute_stock_id} < NUM_ID);
    exe_ok    = bus.i_execute_order && exe_in && (bus.i_execute_order_quantity != '0);
    exe_idx   = exe_in ? bus.i_execute_stock_id : '0;
    pos_ext_d = {pos_q[exe_idx][DW], pos_q[exe_idx]};
    qty_ext_d = {2'b00, bus.i_execute_order_quantity};
    lim_ext_d = {2'b00, max_q[exe_idx]};
    sum_d     = bus.i_execute_order_side ? (pos_ext_d - qty_ext_d) : (pos_ext_d + qty_ext_d);
    clamp_d   = sum_d;
    hit_d     = 1'b0;
    if (sum_d > lim_ext_d) begin
      clamp_d = lim_ext_d;
      hit_d   = exe_ok;
    end else if (sum_d < -lim_ext_d) begin
      clamp_d = -lim_ext_d;
      hit_d   = exe_ok;
    end
    pos_next_d = clamp_d[DW:0];
  end

  assign cfg_ok = bus.i_cfg_we && ({1'b0, bus.i_cfg_stock_id} < NUM_ID);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_STOCKS; i++) begin
        pos_q[i] <= '0;
        max_q[i] <= '1;
        rec_q[i] <= '0;
      end
    end else begin
      if (exe_ok) pos_q[exe_idx] <= pos_next_d;
      // Config lands after the execute of the same cycle has used the old limit.
      if (cfg_ok) begin
        max_q[bus.i_cfg_stock_id] <= bus.i_cfg_max_position;
        rec_q[bus.i_cfg_stock_id] <= bus.i_cfg_max_inv_reciprocal;
      end
    end
  end

  // ---------------- query stage 1: snapshot with forwarding ----------------
  logic signed [DW:0] s1_pos_d;
  logic [FW-1:0]      s1_rec_d;

  always_comb begin
    q_in     = ({1'b0, bus.i_query_stock_id} < NUM_ID);
    q_idx    = q_in ? bus.i_query_stock_id : '0;
    s1_pos_d = '0;
    s1_rec_d = '0;
    if (q_in) begin
      s1_rec_d = rec_q[q_idx];
      if (exe_ok && (bus.i_execute_stock_id == bus.i_query_stock_id))
        s1_pos_d = pos_next_d;
      else
        s1_pos_d = pos_q[q_idx];
    end
  end

  // ---------------- query stage 2: multiply and saturate ----------------
  logic signed [PW-1:0] prod_d;
  logic [PW-FW:0]       prod_hi_d;
  logic signed [FW-1:0] norm_d;

  always_comb begin
    prod_d    = $signed({{(FW+1){s1_pos_q[DW]}}, s1_pos_q}) * $signed({{(DW+2){1'b0}}, s1_rec_q});
    // Integer position times Q-format reciprocal keeps the binary point; the low word is the result.
    prod_hi_d = prod_d[PW-1:FP_FRAC_BITS+INT_BITS-1];
    if ((prod_hi_d == '0) || (prod_hi_d == '1))
      norm_d = prod_d[FW-1:0];
    else if (prod_d[PW-1])
      norm_d = {1'b1, {(FW-1){1'b0}}};
    else
      norm_d = {1'b0, {(FW-1){1'b1}}};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_vld_q   <= 1'b0;
      s1_id_q    <= '0;
      s1_pos_q   <= '0;
      s1_rec_q   <= '0;
      norm_vld_q <= 1'b0;
      norm_id_q  <= '0;
      norm_q     <= '0;
      inv_q      <= '0;
      lim_hit_q  <= 1'b0;
      lim_id_q   <= '0;
    end else begin
      s1_vld_q <= bus.i_query_valid;
      if (bus.i_query_valid) begin
        s1_id_q  <= bus.i_query_stock_id;
        s1_pos_q <= s1_pos_d;
        s1_rec_q <= s1_rec_d;
      end
      norm_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        norm_id_q <= s1_id_q;
        norm_q    <= norm_d;
        inv_q     <= s1_pos_q;
      end
      lim_hit_q <= hit_d;
      if (hit_d) lim_id_q <= exe_idx;
    end
  end

  assign bus.o_norm_valid     = norm_vld_q;
  assign bus.o_norm_stock_id  = norm_id_q;
  assign bus.o_norm_inventory = norm_q;
  assign bus.o_inventory      = inv_q;
  assign bus.o_limit_hit      = lim_hit_q;
  assign bus.o_limit_stock_id = lim_id_q;
endmodule

// File: tb/tb_inventory_tracker.sv
// Directed bench for inventory_tracker (3 stocks, so id 3 is out of range) with a queue scoreboard.
module tb_inventory_tracker;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int FW = 64;
  localparam int FB = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inventory_tracker_if #(.NUM_STOCKS(NS), .DATA_WIDTH(DW), .FP_WORD_SIZE(FW)) bus ();

  inventory_tracker #(.NUM_STOCKS(NS), .DATA_WIDTH(DW), .FP_WORD_SIZE(FW), .FP_FRAC_BITS(FB)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  id;
    logic [63:0] inv;
    logic [63:0] norm;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] id;
  } lim_t;

  exp_t nq[$];
  lim_t lq[$];
  exp_t me;
  lim_t ml;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic idle_inputs();
    bus.i_cfg_we                 = 1'b0;
    bus.i_cfg_stock_id           = '0;
    bus.i_cfg_max_position       = '0;
    bus.i_cfg_max_inv_reciprocal = '0;
    bus.i_execute_order          = 1'b0;
    bus.i_execute_stock_id       = '0;
    bus.i_execute_order_side     = 1'b0;
    bus.i_execute_order_quantity = '0;
    bus.i_query_valid            = 1'b0;
    bus.i_query_stock_id         = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic cfg(input logic [1:0] id, input logic [31:0] mx, input logic [63:0] rec);
    bus.i_cfg_we                 = 1'b1;
    bus.i_cfg_stock_id           = id;
    bus.i_cfg_max_position       = mx;
    bus.i_cfg_max_inv_reciprocal = rec;
  endtask

  task automatic exe(input logic [1:0] id, input logic side, input logic [31:0] qty);
    bus.i_execute_order          = 1'b1;
    bus.i_execute_stock_id       = id;
    bus.i_execute_order_side     = side;
    bus.i_execute_order_quantity = qty;
  endtask

  task automatic qry(input logic [1:0] id);
    bus.i_query_valid    = 1'b1;
    bus.i_query_stock_id = id;
  endtask

  task automatic expq(input logic [1:0] id, input longint inv, input logic [63:0] norm);
    exp_t e;
    e.cyc  = cyc + 2;
    e.id   = id;
    e.inv  = inv;
    e.norm = norm;
    nq.push_back(e);
  endtask

  task automatic expl(input logic [1:0] id);
    lim_t l;
    l.cyc = cyc + 1;
    l.id  = id;
    lq.push_back(l);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_norm_valid"}, 64'(bus.o_norm_valid), 64'd0);
    chk({tag, "_norm_id"}, 64'(bus.o_norm_stock_id), 64'd0);
    chk({tag, "_norm_inv"}, bus.o_norm_inventory, 64'd0);
    chk({tag, "_inventory"}, 64'(bus.o_inventory), 64'd0);
    chk({tag, "_limit_hit"}, 64'(bus.o_limit_hit), 64'd0);
    chk({tag, "_limit_id"}, 64'(bus.o_limit_stock_id), 64'd0);
  endtask

  // Monitor: every result or flag pulse must match the head of its queue, on the predicted cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_norm_valid) begin
        if (nq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL norm_unexpected: got valid id=%0d at cycle %0d, required none", bus.o_norm_stock_id, cyc);
        end else begin
          me = nq.pop_front();
          chk("norm_cycle", 64'(cyc), 64'(me.cyc));
          chk("norm_id", 64'(bus.o_norm_stock_id), 64'(me.id));
          chk("inventory", 64'(bus.o_inventory), me.inv);
          chk("norm_inventory", bus.o_norm_inventory, me.norm);
        end
      end else if (nq.size() != 0 && cyc > nq[0].cyc) begin
        me = nq.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL norm_missing: no valid by cycle %0d, required at cycle %0d", cyc, me.cyc);
      end
      if (bus.o_limit_hit) begin
        if (lq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL limit_unexpected: got hit id=%0d at cycle %0d, required none", bus.o_limit_stock_id, cyc);
        end else begin
          ml = lq.pop_front();
          chk("limit_cycle", 64'(cyc), 64'(ml.cyc));
          chk("limit_id", 64'(bus.o_limit_stock_id), 64'(ml.id));
        end
      end else if (lq.size() != 0 && cyc > lq[0].cyc) begin
        ml = lq.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL limit_missing: no hit by cycle %0d, required at cycle %0d", cyc, ml.cyc);
      end
    end
  end

  initial begin
    idle_inputs();
    #12;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state: stock 0 reads zero.
    tick(); qry(0); expq(0, 0, 64'd0);
    tick();
    // Stock 1: limit 1000, reciprocal ~1/1000.
    tick(); cfg(1, 32'd1000, 64'h418937);
    tick(); exe(1, 1'b0, 32'd500);
    tick(); qry(1); expq(1, 500, 64'h7FFFFF6C);
    // Landing exactly on -limit does not flag; one more sell clamps and flags.
    tick(); exe(1, 1'b1, 32'd1500);
    tick(); qry(1); expq(1, -1000, -64'sd4294967000);
    tick(); exe(1, 1'b1, 32'd1); expl(1);
    tick(); qry(1); expq(1, -1000, -64'sd4294967000);
    // Forwarded execute, then saturation at both ends with a huge reciprocal.
    tick(); exe(2, 1'b0, 32'd7); qry(2); expq(2, 7, 64'd0);
    tick(); cfg(2, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(); qry(2); expq(2, 7, 64'h7FFF_FFFF_FFFF_FFFF);
    tick(); exe(2, 1'b1, 32'd20);
    tick(); qry(2); expq(2, -13, 64'h8000_0000_0000_0000);
    // Same-cycle cfg + execute + query: old limit and old reciprocal apply.
    tick(); cfg(0, 32'd10, 64'h1_0000_0000); exe(0, 1'b0, 32'd25); qry(0); expq(0, 25, 64'd0);
    tick(); qry(0); expq(0, 25, 64'd107374182400);
    tick(); exe(0, 1'b0, 32'd0);
    tick(); qry(0); expq(0, 25, 64'd107374182400);
    tick(); exe(0, 1'b0, 32'd1); expl(0); qry(0); expq(0, 10, 64'd42949672960);
    // Back-to-back queries including the out-of-range id.
    tick(); qry(0); expq(0, 10, 64'd42949672960);
    tick(); qry(1); expq(1, -1000, -64'sd4294967000);
    tick(); qry(2); expq(2, -13, 64'h8000_0000_0000_0000);
    tick(); qry(3); expq(3, 0, 64'd0);
    // Out-of-range config and execute are ignored.
    tick(); cfg(3, 32'd5, 64'h1_0000_0000);
    tick(); exe(3, 1'b1, 32'hFFFF_FFFF);
    tick(); exe(3, 1'b0, 32'd100); qry(3); expq(3, 0, 64'd0);
    tick(); qry(0); expq(0, 10, 64'd42949672960);
    repeat (3) tick();

    // Reset with queries in flight.
    tick(); qry(1); expq(1, -1000, -64'sd4294967000);
    tick(); qry(1);
    tick(); qry(1);
    #6;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    nq.delete();
    lq.delete();
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    tick(); qry(0); expq(0, 0, 64'd0);
    tick(); qry(1); expq(1, 0, 64'd0);
    tick(); qry(2); expq(2, 0, 64'd0);
    repeat (5) tick();

    chk("norm_queue_drained", 64'(nq.size()), 64'd0);
    chk("limit_queue_drained", 64'(lq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
